// File: rtl/usb_tx_serializer.sv
// USB transmit line driver: byte stream in, NRZI-encoded and bit-stuffed {VP,VM}
// line states out, framed with SYNC and EOP, plus the line output-enable.
module usb_tx_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit LOW_SPEED    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       txValid,
  input  logic [7:0] txData,
  output logic       txReady,
  output logic       busy,
  output logic [1:0] usbDataOut,
  output logic       usbOE
);

  localparam logic [1:0] J   = LOW_SPEED ? 2'b01 : 2'b10;
  localparam logic [1:0] K   = LOW_SPEED ? 2'b10 : 2'b01;
  localparam logic [1:0] SE0 = 2'b00;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [2:0]      bit_r, bit_s;
  logic [2:0]      ones_r, ones_s;
  logic [6:0]      shift_r, shift_s;   // bits of the field still to be launched
  logic            lvl_r, lvl_s;       // NRZI level, 1 means K
  logic            eop_r, eop_s;
  logic [1:0]      line_r, line_s;
  logic            oe_r, oe_s;
  logic            busy_r, busy_s;
  logic            tick_s, in_frame_s, stuff_s, load_s;

  // Launches one bit: returns {new level, new ones count}.
  function automatic logic [3:0] nrzi(input logic lvl, input logic [2:0] ones, input logic b);
    if (b) begin
      nrzi = {lvl, ones + 3'd1};
    end else begin
      nrzi = {~lvl, 3'd0};
    end
  endfunction

  assign tick_s     = (cnt_r == LAST);
  assign in_frame_s = (state_r == SYNC) || (state_r == DATA);
  assign stuff_s    = tick_s && in_frame_s && (ones_r == 3'd6);
  // A pending stuff bit always goes out before the load point is reached.
  assign load_s     = tick_s && in_frame_s && (ones_r != 3'd6) && (bit_r == 3'd7);
  assign txReady    = load_s && txValid;

  assign usbDataOut = line_r;
  assign usbOE      = oe_r;
  assign busy       = busy_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:       if (txValid) state_s = SYNC; else state_s = IDLE;
      SYNC, DATA: if (load_s) state_s = txValid ? DATA : EOP_SE0; else state_s = state_r;
      EOP_SE0:    if (tick_s && eop_r) state_s = EOP_J; else state_s = EOP_SE0;
      EOP_J:      if (tick_s) state_s = IDLE; else state_s = EOP_J;
      default:    state_s = IDLE;
    endcase
  end

  // Bit timing, stuffing, NRZI and next output values.
  always_comb begin
    cnt_s   = tick_s ? '0 : cnt_r + CW'(1);
    bit_s   = bit_r;
    ones_s  = ones_r;
    shift_s = shift_r;
    lvl_s   = lvl_r;
    eop_s   = eop_r;
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        bit_s = 3'd0;
        if (txValid) begin
          shift_s         = 7'h40;
          {lvl_s, ones_s} = nrzi(1'b0, 3'd0, 1'b0);
        end else begin
          lvl_s  = 1'b0;
          ones_s = 3'd0;
        end
      end
      SYNC, DATA: begin
        if (!tick_s) begin
          bit_s = bit_r;
        end else if (stuff_s) begin
          lvl_s  = ~lvl_r;
          ones_s = 3'd0;
        end else if (!load_s) begin
          bit_s           = bit_r + 3'd1;
          shift_s         = {1'b0, shift_r[6:1]};
          {lvl_s, ones_s} = nrzi(lvl_r, ones_r, shift_r[0]);
        end else if (txValid) begin
          bit_s           = 3'd0;
          shift_s         = txData[7:1];
          {lvl_s, ones_s} = nrzi(lvl_r, ones_r, txData[0]);
        end else begin
          eop_s = 1'b0;
        end
      end
      EOP_SE0: begin
        if (tick_s) eop_s = 1'b1; else eop_s = eop_r;
      end
      EOP_J: begin
        if (tick_s) begin
          lvl_s  = 1'b0;
          ones_s = 3'd0;
        end else begin
          lvl_s = lvl_r;
        end
      end
      default: begin
        cnt_s = '0;
      end
    endcase

    oe_s   = (state_s != IDLE);
    busy_s = (state_s != IDLE);
    if (state_s == EOP_SE0) begin
      line_s = SE0;
    end else if ((state_s == SYNC) || (state_s == DATA)) begin
      line_s = lvl_s ? K : J;
    end else begin
      line_s = J;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      bit_r   <= 3'd0;
      ones_r  <= 3'd0;
      shift_r <= 7'h00;
      lvl_r   <= 1'b0;
      eop_r   <= 1'b0;
      line_r  <= J;
      oe_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      ones_r  <= ones_s;
      shift_r <= shift_s;
      lvl_r   <= lvl_s;
      eop_r   <= eop_s;
      line_r  <= line_s;
      oe_r    <= oe_s;
      busy_r  <= busy_s;
    end
  end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Self-checking bench for usb_tx_serializer: table of packets, a bit-level
// reference model filling a per-clock scoreboard, plus reset and low-speed sequences.
module tb_usb_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, txv, sel;
  logic [7:0] txd;
  logic       tx_valid1, tx_valid2;
  logic       ready1, busy1, oe1, ready2, busy2, oe2;
  logic [1:0] line1, line2;
  logic       m_rdy, m_busy, m_oe;
  logic [1:0] m_line;

  assign tx_valid1 = txv & ~sel;
  assign tx_valid2 = txv & sel;
  assign m_rdy  = sel ? ready2 : ready1;
  assign m_busy = sel ? busy2  : busy1;
  assign m_oe   = sel ? oe2    : oe1;
  assign m_line = sel ? line2  : line1;

  usb_tx_serializer #(.CLKS_PER_BIT(4), .LOW_SPEED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .txValid(tx_valid1), .txData(txd),
    .txReady(ready1), .busy(busy1), .usbDataOut(line1), .usbOE(oe1)
  );

  usb_tx_serializer #(.CLKS_PER_BIT(32), .LOW_SPEED(1'b1)) dut_ls (
    .clk(clk), .rst_n(rst_n), .txValid(tx_valid2), .txData(txd),
    .txReady(ready2), .busy(busy2), .usbDataOut(line2), .usbOE(oe2)
  );

  // out = {oe, busy, line[1:0], txReady}
  typedef struct packed {
    logic       load;
    logic [7:0] data;
    logic [4:0] out;
  } exp_t;

  typedef struct {
    int          n;
    logic [23:0] bytes;
    int          clocks;
    bit          jit;
    int          c;
    logic [1:0]  jj;
    logic [1:0]  kk;
    bit          ls;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[9];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: SYNC + bytes, LSB first, NRZI, stuff after six 1s, then SE0 SE0 J.
  task automatic build(input int n, input logic [23:0] bytes, input int c,
                       input logic [1:0] jj, input logic [1:0] kk);
    logic       k;
    int         ones;
    logic [7:0] fb;
    logic [1:0] lv[$];
    exp_t       e;
    k = 1'b0;
    ones = 0;
    for (int f = 0; f <= n; f++) begin
      if (f == 0) fb = 8'h80;
      else        fb = bytes[8*(f-1) +: 8];
      lv.delete();
      for (int i = 0; i < 8; i++) begin
        if (!fb[i]) begin k = ~k; ones = 0; end
        else ones++;
        lv.push_back(k ? kk : jj);
        if (ones == 6) begin
          k = ~k;
          ones = 0;
          lv.push_back(k ? kk : jj);
        end
      end
      for (int p = 0; p < lv.size(); p++) begin
        for (int q = 0; q < c; q++) begin
          e.load = (p == lv.size() - 1) && (q == c - 1);
          e.out  = {1'b1, 1'b1, lv[p], e.load && (f < n)};
          e.data = (e.load && (f < n)) ? bytes[8*f +: 8] : 8'h00;
          exp_q.push_back(e);
        end
      end
    end
    for (int q = 0; q < 2 * c; q++) exp_q.push_back({1'b0, 8'h00, 5'b11_00_0});
    for (int q = 0; q < c; q++)     exp_q.push_back({1'b0, 8'h00, {2'b11, jj, 1'b0}});
  endtask

  // Called at a negedge with the selected DUT expected idle; returns at the
  // negedge of the first idle clock after the packet.
  task automatic run_packet(input int idx);
    vec_t v;
    exp_t e;
    int   remaining, cyc, busy_cnt, t;
    v = tbl[idx];
    sel = v.ls;
    t = 0;
    while (m_busy === 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("pkt%0d idle_before", idx), {31'd0, m_busy}, 32'd0);
    build(v.n, v.bytes, v.c, v.jj, v.kk);
    remaining = v.n;
    cyc = 0;
    busy_cnt = 0;
    txv = 1'b1;
    txd = (v.n > 0) ? v.bytes[7:0] : 8'($urandom);
    @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.load) begin
        txv = e.out[0];
        txd = e.out[0] ? e.data : 8'($urandom);
        if (e.out[0]) remaining--;
      end else if (v.jit) begin
        txv = 1'($urandom);
        txd = 8'($urandom);
      end else begin
        txv = (remaining > 0);
        txd = 8'($urandom);
      end
      @(negedge clk);
      if (m_busy) busy_cnt++;
      check($sformatf("pkt%0d cyc%0d {oe,busy,line,rdy}", idx, cyc),
            {27'd0, m_oe, m_busy, m_line, m_rdy}, {27'd0, e.out});
      cyc++;
      @(posedge clk); #1;
    end
    txv = 1'b0;
    check($sformatf("pkt%0d busy_clocks", idx), busy_cnt, v.clocks);
    @(negedge clk);
    check($sformatf("pkt%0d idle_after", idx),
          {27'd0, m_oe, m_busy, m_line, m_rdy}, {27'd0, 2'b00, v.jj, 1'b0});
  endtask

  initial begin
    tbl[0] = '{0, 24'h000000,  44, 1'b0,  4, 2'b10, 2'b01, 1'b0};
    tbl[1] = '{1, 24'h000000,  76, 1'b0,  4, 2'b10, 2'b01, 1'b0};
    tbl[2] = '{1, 24'h0000FF,  80, 1'b1,  4, 2'b10, 2'b01, 1'b0};
    tbl[3] = '{2, 24'h00FF3F, 116, 1'b1,  4, 2'b10, 2'b01, 1'b0};
    tbl[4] = '{1, 24'h0000FC,  80, 1'b1,  4, 2'b10, 2'b01, 1'b0};
    tbl[5] = '{2, 24'h005AA5, 108, 1'b1,  4, 2'b10, 2'b01, 1'b0};
    tbl[6] = '{3, 24'hFFFFFF, 156, 1'b1,  4, 2'b10, 2'b01, 1'b0};
    tbl[7] = '{0, 24'h000000, 352, 1'b0, 32, 2'b01, 2'b10, 1'b1};
    tbl[8] = '{1, 24'h000000, 608, 1'b1, 32, 2'b01, 2'b10, 1'b1};

    rst_n = 1'b0;
    txv   = 1'b0;
    txd   = 8'h00;
    sel   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset dut {oe,busy,line,rdy}", {27'd0, oe1, busy1, line1, ready1}, {27'd0, 5'b00_10_0});
    check("reset dut_ls {oe,busy,line}", {28'd0, oe2, busy2, line2}, {28'd0, 4'b00_01});
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back packets, one idle clock apart.
    for (int i = 0; i < 7; i++) run_packet(i);

    // Asynchronous reset during DATA bit 3 of a 8'h00 byte.
    txv = 1'b1;
    txd = 8'h00;
    @(posedge clk); #1;
    repeat (45) @(posedge clk);
    @(negedge clk);
    check("pre_reset oe", {31'd0, oe1}, 32'd1);
    check("pre_reset line", {30'd0, line1}, {30'd0, 2'b01});
    #1 rst_n = 1'b0;
    #1;
    check("async_reset {oe,busy,line,rdy}", {27'd0, oe1, busy1, line1, ready1}, {27'd0, 5'b00_10_0});
    txv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_packet(0);

    // Low-speed instance, 32 clocks per bit.
    sel = 1'b1;
    check("ls idle line", {30'd0, line2}, {30'd0, 2'b01});
    run_packet(7);
    run_packet(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
